// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline stage register with valid/ready handshake, flush and $0-write suppression.
// Define MEM_WB_SKID_EN to add a skid register so ready_m is registered and has no path from ready_w.
module mem_wb_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int WB_W       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  valid_m,
    output logic                  ready_m,
    input  logic [WB_W-1:0]       WBM,
    input  logic [DATA_W-1:0]     ReadDataM,
    input  logic [DATA_W-1:0]     ALUResultM,
    input  logic [REG_ADDR_W-1:0] RegDstM,
    output logic                  valid_w,
    input  logic                  ready_w,
    output logic [WB_W-1:0]       WBW,
    output logic                  RegWrite,
    output logic                  MemtoReg,
    output logic [DATA_W-1:0]     ReadDataW,
    output logic [DATA_W-1:0]     ALUResultW,
    output logic [REG_ADDR_W-1:0] RegDstW
);

    // Writes to register 0 are architecturally discarded, so drop RegWrite at capture.
    function automatic logic [WB_W-1:0] suppress_r0(input logic [WB_W-1:0] wb,
                                                    input logic [REG_ADDR_W-1:0] rd);
        logic [WB_W-1:0] r;
        r = wb;
        if (rd == '0) r[0] = 1'b0;
        return r;
    endfunction

    logic                  accept;
    logic                  load_out;
    logic                  src_vld;
    logic [WB_W-1:0]       src_wb;
    logic [DATA_W-1:0]     src_rdata;
    logic [DATA_W-1:0]     src_alu;
    logic [REG_ADDR_W-1:0] src_rd;

    logic                  vld_p1;
    logic [WB_W-1:0]       wb_p1;
    logic [DATA_W-1:0]     rdata_p1;
    logic [DATA_W-1:0]     alu_p1;
    logic [REG_ADDR_W-1:0] rd_p1;

    assign accept   = valid_m & ready_m;
    assign load_out = ~vld_p1 | ready_w;

`ifdef MEM_WB_SKID_EN
    logic                  vld_p0;
    logic [WB_W-1:0]       wb_p0;
    logic [DATA_W-1:0]     rdata_p0;
    logic [DATA_W-1:0]     alu_p0;
    logic [REG_ADDR_W-1:0] rd_p0;

    assign ready_m = ~vld_p0 & ~rst;

    // Skid entry is always older than anything on the input, so it drains first.
    assign src_vld   = vld_p0 | accept;
    assign src_wb    = vld_p0 ? wb_p0    : suppress_r0(WBM, RegDstM);
    assign src_rdata = vld_p0 ? rdata_p0 : ReadDataM;
    assign src_alu   = vld_p0 ? alu_p0   : ALUResultM;
    assign src_rd    = vld_p0 ? rd_p0    : RegDstM;

    // ---- stage p0: skid register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
        end else if (flush) begin
            vld_p0 <= 1'b0;
        end else if (load_out) begin
            vld_p0 <= 1'b0;
        end else if (accept) begin
            vld_p0 <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept & ~load_out) begin
            wb_p0    <= suppress_r0(WBM, RegDstM);
            rdata_p0 <= ReadDataM;
            alu_p0   <= ALUResultM;
            rd_p0    <= RegDstM;
        end
    end
`else
    assign ready_m = load_out & ~rst;

    assign src_vld   = accept;
    assign src_wb    = suppress_r0(WBM, RegDstM);
    assign src_rdata = ReadDataM;
    assign src_alu   = ALUResultM;
    assign src_rd    = RegDstM;
`endif

    // ---- stage p1: output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            wb_p1    <= '0;
            rdata_p1 <= '0;
            alu_p1   <= '0;
            rd_p1    <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
            wb_p1  <= '0;
        end else if (load_out) begin
            vld_p1 <= src_vld;
            if (src_vld) begin
                wb_p1    <= src_wb;
                rdata_p1 <= src_rdata;
                alu_p1   <= src_alu;
                rd_p1    <= src_rd;
            end
        end
    end

    assign valid_w    = vld_p1;
    assign WBW        = wb_p1;
    assign ReadDataW  = rdata_p1;
    assign ALUResultW = alu_p1;
    assign RegDstW    = rd_p1;
    assign RegWrite   = wb_p1[0] & vld_p1;
    assign MemtoReg   = wb_p1[1] & vld_p1;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Bench for mem_wb_pipe_reg: directed scenarios then random traffic against a queue-based model.
module tb_mem_wb_pipe_reg;
    localparam int DATA_W = 32;
    localparam int REG_ADDR_W = 5;
    localparam int WB_W = 2;
`ifdef MEM_WB_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic                  clk = 1'b0;
    logic                  rst, flush, valid_m, ready_m, valid_w, ready_w;
    logic [WB_W-1:0]       WBM, WBW;
    logic                  RegWrite, MemtoReg;
    logic [DATA_W-1:0]     ReadDataM, ALUResultM, ReadDataW, ALUResultW;
    logic [REG_ADDR_W-1:0] RegDstM, RegDstW;

    mem_wb_pipe_reg #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .WB_W(WB_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .valid_m(valid_m), .ready_m(ready_m),
        .WBM(WBM), .ReadDataM(ReadDataM), .ALUResultM(ALUResultM), .RegDstM(RegDstM),
        .valid_w(valid_w), .ready_w(ready_w),
        .WBW(WBW), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .ReadDataW(ReadDataW), .ALUResultW(ALUResultW), .RegDstW(RegDstW)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WB_W-1:0]       wb;
        logic [DATA_W-1:0]     rdata;
        logic [DATA_W-1:0]     alu;
        logic [REG_ADDR_W-1:0] rd;
    } ent_t;

    ent_t q[$];     // entries held by the stage, oldest first
    ent_t shown;    // what the output pins should present
    int   checks = 0;
    int   errors = 0;
    bit   last_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_ready();
        if (rst) return 1'b0;
        if (CAP == 2) return q.size() < 2;
        return (q.size() == 0) || ready_w;
    endfunction

    // One clock: check ready_m before the edge, advance the model, check outputs after.
    task automatic cycle();
        bit   acc, xf;
        ent_t e;
        #1;
        chk("ready_m", {63'd0, ready_m}, {63'd0, exp_ready()});
        acc = valid_m && exp_ready();
        xf  = (q.size() > 0) && ready_w;
        e.wb = WBM;
        if (RegDstM == '0) e.wb[0] = 1'b0;
        e.rdata = ReadDataM;
        e.alu   = ALUResultM;
        e.rd    = RegDstM;
        @(posedge clk);
        last_acc = 1'b0;
        if (rst) begin
            q.delete();
            shown = '0;
        end else if (flush) begin
            q.delete();
            shown.wb = '0;
        end else begin
            if (xf) void'(q.pop_front());
            if (acc) begin
                q.push_back(e);
                last_acc = 1'b1;
            end
            if (q.size() > 0) shown = q[0];
        end
        #1;
        chk("valid_w",    {63'd0, valid_w},  {63'd0, q.size() > 0});
        chk("WBW",        64'(WBW),          64'(shown.wb));
        chk("RegWrite",   {63'd0, RegWrite}, {63'd0, shown.wb[0] && (q.size() > 0)});
        chk("MemtoReg",   {63'd0, MemtoReg}, {63'd0, shown.wb[1] && (q.size() > 0)});
        chk("ReadDataW",  64'(ReadDataW),    64'(shown.rdata));
        chk("ALUResultW", 64'(ALUResultW),   64'(shown.alu));
        chk("RegDstW",    64'(RegDstW),      64'(shown.rd));
    endtask

    task automatic drive(input bit v, input logic [1:0] wb, input logic [4:0] rd,
                         input logic [31:0] alu);
        valid_m    = v;
        WBM        = wb;
        RegDstM    = rd;
        ALUResultM = alu;
        ReadDataM  = $urandom;
    endtask

    initial begin
        int idx;
        int budget;
        shown = '0;
        rst = 1'b1; flush = 1'b0; ready_w = 1'b0;
        drive(1'b0, 2'b00, 5'd0, 32'd0);
        ReadDataM = '0;
        // Reset held for two cycles
        cycle();
        cycle();
        rst = 1'b0;

        // Back-to-back stream of four entries
        ready_w = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b01, 5'(3 + i), 32'h10 + 32'(i));
            cycle();
        end
        drive(1'b0, 2'b00, 5'd0, 32'd0);
        cycle();
        cycle();

        // Destination $0 with RegWrite|MemtoReg requested
        drive(1'b1, 2'b11, 5'd0, 32'h55);
        cycle();
        drive(1'b0, 2'b00, 5'd0, 32'd0);
        cycle();

        // Back-pressure: offer 0x20..0x25, consumer stalled for 3 cycles
        idx = 0;
        budget = 0;
        while (idx < 6 && budget < 50) begin
            ready_w = (budget >= 3);
            drive(1'b1, 2'b01, 5'(8 + idx), 32'h20 + 32'(idx));
            cycle();
            if (last_acc) idx++;
            budget++;
        end
        chk("bp_all_accepted", 64'(idx), 64'd6);
        drive(1'b0, 2'b00, 5'd0, 32'd0);
        ready_w = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Flush with the stage full and 0x99 on the input
        ready_w = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'b01, 5'd7, 32'h30 + 32'(i));
            cycle();
        end
        flush = 1'b1;
        drive(1'b1, 2'b01, 5'd9, 32'h99);
        cycle();
        flush = 1'b0;
        drive(1'b0, 2'b00, 5'd0, 32'd0);
        ready_w = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Reset pulse while stalled and full
        ready_w = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b11, 5'd12, 32'h40 + 32'(i));
            cycle();
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drive(1'b0, 2'b00, 5'd0, 32'd0);
        ready_w = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Random traffic including sporadic flush and reset
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom % 50) == 0;
            flush   = ($urandom % 25) == 0;
            ready_w = ($urandom % 3) != 0;
            drive(($urandom % 4) != 0, 2'($urandom),
                  (($urandom % 8) == 0) ? 5'd0 : 5'($urandom), $urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
